// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//
// Single-clock front end for dual_port_ram. NUM_REQ requesters share the RAM
// through a round-robin arbiter, with at most one read or write granted per
// cycle. After reset, and again on a clr pulse, the RAM is cleared by raising
// ram_wr_rst for one cycle (the CLR state). Read data returns one cycle after
// the grant and is tagged with the requester id. Both RAM clocks are clk.
//
// Optional feature (compile-time macro RAM_ARB_ADDR_CHECK_EN):
//   Defined     - a granted access with addr >= DEPTH is still granted. Its RAM
//                 enable is suppressed and err pulses in the grant cycle. A read
//                 still returns rsp_valid, with rsp_data forced to 0.
//   Not defined - no range check. The address goes to the RAM unchanged and err
//                 is tied to 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               pulse: clear the RAM again (ignored while busy)
//   req/we/addr/wdata per-requester request, direction, packed address/data
//   gnt               one-hot grant, combinational, access happens this cycle
//   rsp_valid/rsp_id/rsp_data   read response, one cycle after the grant
//   busy              high while in CLR
//   err               out-of-range access pulse (only with the check enabled)
//   ram_*             connections to the dual_port_ram write/read ports
// ---------------------------------------------------------------------------
module ram_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*AW-1:0]         addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rsp_valid,
    output logic [IW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic                          err,
    output logic                          ram_wr_rst,
    output logic                          ram_wr_en,
    output logic [AW-1:0]                 ram_wr_addr,
    output logic [DATA_WIDTH-1:0]         ram_wr_data,
    output logic                          ram_rd_en,
    output logic [AW-1:0]                 ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

    typedef enum logic {CLR = 1'b0, RUN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;

    logic                  gnt_any;
    logic [IW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    gnt_vec;
    logic                  win_we;
    logic [AW-1:0]         win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  in_range;

    // Round-robin search starting at ptr_q and wrapping past NUM_REQ-1.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        // No grants while clearing, or in the cycle a clear is requested.
        if (state_q != RUN || clr) gnt_any = 1'b0;
        gnt_vec = '0;
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    // Select the winner's request fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                win_we    = we[i];
                win_addr  = addr[i*AW +: AW];
                win_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef RAM_ARB_ADDR_CHECK_EN
    logic rsp_zero_q, rsp_zero_d;
    assign in_range = (int'(win_addr) < DEPTH);
    assign err      = gnt_any & ~in_range;
    // An out-of-range read never touched the RAM, so its response is 0.
    assign rsp_data = rsp_zero_q ? '0 : ram_rd_data;
    assign rsp_zero_d = rsp_valid_d ? ~in_range : rsp_zero_q;
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
    assign rsp_data = ram_rd_data;
`endif

    assign gnt         = gnt_vec;
    assign ram_wr_en   = gnt_any &  win_we & in_range;
    assign ram_rd_en   = gnt_any & ~win_we & in_range;
    assign ram_wr_addr = win_addr;
    assign ram_wr_data = win_wdata;
    assign ram_rd_addr = win_addr;
    assign busy        = (state_q == CLR);
    assign ram_wr_rst  = (state_q == CLR);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR:     state_d = RUN;              // clear lasts exactly one cycle
            RUN:     if (clr) state_d = CLR;
            default: state_d = CLR;
        endcase

        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

        // The response flag is raised even for a read out of range or one
        // granted just before CLR, so every accepted read gets a response.
        rsp_valid_d = gnt_any & ~win_we;
        rsp_id_d    = rsp_valid_d ? gnt_idx : rsp_id_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLR;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
`ifdef RAM_ARB_ADDR_CHECK_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
`ifdef RAM_ARB_ADDR_CHECK_EN
            rsp_zero_q  <= rsp_zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
//
// Directed bench for ram_access_arbiter. A small behavioural dual-port RAM
// sits behind the arbiter: synchronous write, registered read, and clear on
// wr_rst. Inputs change 1 time unit after a rising edge. Outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 10;
    localparam int AW      = 4;
    localparam int IW      = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clr;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ*AW-1:0] addr;
    logic [NUM_REQ*DW-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [DW-1:0]         rsp_data;
    logic                  busy, err;
    logic                  ram_wr_rst, ram_wr_en, ram_rd_en;
    logic [AW-1:0]         ram_wr_addr, ram_rd_addr;
    logic [DW-1:0]         ram_wr_data, ram_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    ram_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .err(err), .ram_wr_rst(ram_wr_rst),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM (16 words so that out-of-range addresses are harmless).
    logic [DW-1:0] mem [16];
    always_ff @(posedge clk) begin
        if (ram_wr_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        req = 4'b1111;                       // must stay ungranted in CLR
        sample();
        n_checks++; if (busy !== 1'b1 || ram_wr_rst !== 1'b1) begin n_fail++; $display("FAIL clr_cycle busy=%b wr_rst=%b exp=1/1", busy, ram_wr_rst); end
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL clr_cycle_gnt got=%b exp=0000", gnt); end
        n_checks++; if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL clr_cycle_en rd=%b wr=%b exp=0/0", ram_rd_en, ram_wr_en); end
        tick();
        req = '0;
        sample();
        n_checks++; if (busy !== 1'b0 || ram_wr_rst !== 1'b0) begin n_fail++; $display("FAIL run_busy busy=%b wr_rst=%b exp=0/0", busy, ram_wr_rst); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_gnt [5];
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
        tick();
        req = 4'b1111; we = 4'b0000;
        for (int i = 0; i < NUM_REQ; i++) addr[i*AW +: AW] = AW'(i);
        for (int c = 0; c < 5; c++) begin
            sample();
            n_checks++; if (gnt !== exp_gnt[c]) begin n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt[c]); end
            n_checks++; if (ram_rd_en !== 1'b1) begin n_fail++; $display("FAIL rr_rd_en c=%0d got=%b exp=1", c, ram_rd_en); end
            if (c == 0) begin
                n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_valid c=0 got=%b exp=0", rsp_valid); end
            end else begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(c - 1)) begin n_fail++; $display("FAIL rr_rsp c=%0d valid=%b id=%0d exp=1/%0d", c, rsp_valid, rsp_id, c - 1); end
                n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rr_rsp_data c=%0d got=%h exp=00", c, rsp_data); end
            end
            tick();
        end
        req = '0;
        sample();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rr_last_rsp valid=%b id=%0d exp=1/0", rsp_valid, rsp_id); end
        n_checks++; if (gnt !== 4'b0000 || ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle gnt=%b rd_en=%b exp=0000/0", gnt, ram_rd_en); end
    endtask

    task automatic test_write_read();
        tick();
        req = 4'b0001; we = 4'b0001; addr[0 +: AW] = 4'd3; wdata[0 +: DW] = 8'hA5;
        sample();
        n_checks++; if (gnt !== 4'b0001 || ram_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_gnt gnt=%b wr_en=%b exp=0001/1", gnt, ram_wr_en); end
        n_checks++; if (ram_wr_addr !== 4'd3 || ram_wr_data !== 8'hA5) begin n_fail++; $display("FAIL wr_port addr=%0d data=%h exp=3/a5", ram_wr_addr, ram_wr_data); end
        tick();
        we = 4'b0000;
        sample();
        n_checks++; if (gnt !== 4'b0001 || ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd3) begin n_fail++; $display("FAIL rd_gnt gnt=%b rd_en=%b addr=%0d exp=0001/1/3", gnt, ram_rd_en, ram_rd_addr); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp got=%b exp=0", rsp_valid); end
        tick();
        req = '0;
        sample();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_rsp valid=%b id=%0d data=%h exp=1/0/a5", rsp_valid, rsp_id, rsp_data); end
    endtask

    task automatic test_clear();
        // ptr is 1 here; requester 1 reads address 3 (holds A5 before the clear).
        tick();
        req = 4'b0010; we = 4'b0000; addr[1*AW +: AW] = 4'd3; clr = 1'b1;
        sample();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_req_cycle gnt=%b busy=%b exp=0000/0", gnt, busy); end
        tick();
        // clr held into the CLR cycle must be ignored.
        sample();
        n_checks++; if (busy !== 1'b1 || ram_wr_rst !== 1'b1 || gnt !== 4'b0000) begin n_fail++; $display("FAIL clr_state busy=%b wr_rst=%b gnt=%b exp=1/1/0000", busy, ram_wr_rst, gnt); end
        tick();
        clr = 1'b0;
        sample();
        n_checks++; if (busy !== 1'b0 || gnt !== 4'b0010 || ram_rd_en !== 1'b1) begin n_fail++; $display("FAIL clr_after busy=%b gnt=%b rd_en=%b exp=0/0010/1", busy, gnt, ram_rd_en); end
        tick();
        req = '0;
        sample();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL clr_rsp valid=%b id=%0d data=%h exp=1/1/00", rsp_valid, rsp_id, rsp_data); end
    endtask

    task automatic test_addr_range();
        // ptr is 2; requester 2 writes then reads address 12 (beyond DEPTH).
        tick();
        req = 4'b0100; we = 4'b0100; addr[2*AW +: AW] = 4'd12; wdata[2*DW +: DW] = 8'h5A;
        sample();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL oob_wr_gnt got=%b exp=0100", gnt); end
`ifdef RAM_ARB_ADDR_CHECK_EN
        n_checks++; if (err !== 1'b1 || ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL oob_wr err=%b wr_en=%b exp=1/0", err, ram_wr_en); end
`else
        n_checks++; if (err !== 1'b0 || ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd12) begin n_fail++; $display("FAIL oob_wr err=%b wr_en=%b addr=%0d exp=0/1/12", err, ram_wr_en, ram_wr_addr); end
`endif
        tick();
        we = 4'b0000;
        sample();
`ifdef RAM_ARB_ADDR_CHECK_EN
        n_checks++; if (gnt !== 4'b0100 || err !== 1'b1 || ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL oob_rd gnt=%b err=%b rd_en=%b exp=0100/1/0", gnt, err, ram_rd_en); end
`else
        n_checks++; if (gnt !== 4'b0100 || err !== 1'b0 || ram_rd_en !== 1'b1) begin n_fail++; $display("FAIL oob_rd gnt=%b err=%b rd_en=%b exp=0100/0/1", gnt, err, ram_rd_en); end
`endif
        tick();
        req = '0;
        sample();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oob_err_pulse got=%b exp=0", err); end
`ifdef RAM_ARB_ADDR_CHECK_EN
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL oob_rsp valid=%b id=%0d data=%h exp=1/2/00", rsp_valid, rsp_id, rsp_data); end
`else
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h5A) begin n_fail++; $display("FAIL oob_rsp valid=%b id=%0d data=%h exp=1/2/5a", rsp_valid, rsp_id, rsp_data); end
`endif
    endtask

    task automatic test_reset_midop();
        // ptr is 3; requester 3 read is granted, then reset hits the same cycle.
        tick();
        req = 4'b1000; we = 4'b0000;
        sample();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_gnt got=%b exp=1000", gnt); end
        rst_n = 1'b0;
        req = '0;
        #1;
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_async busy=%b gnt=%b exp=1/0000", busy, gnt); end
        tick();
        rst_n = 1'b1;
        sample();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_dropped valid=%b busy=%b exp=0/1", rsp_valid, busy); end
        tick();
        req = 4'b1111;
        sample();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got=%b exp=0", rsp_valid); end
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset gnt=%b exp=0001", gnt); end
        tick();
        req = '0;
        sample();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_rsp valid=%b id=%0d exp=1/0", rsp_valid, rsp_id); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_clear();
        test_addr_range();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
